ecc_pmul_result_capture: RTL

- Sits directly downstream of the P-256 point multiplier in the crypt_clk domain.
- Consumes the multiplier's word-serial result write stream (rx/ry: address, write-enable, 32-bit data) and assembles the affine result into two 8-word stores.
- On the multiplier's rdy rising edge, judges completeness and flags the result valid or in error.
- Serves words back to the register block with registered reads and optional MSB-first ordering.

---
 rtl/ecc_pmul_result_capture.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ecc_pmul_result_capture.sv
// ecc_pmul_result_capture: captures the P-256 point multiplier's affine
// result words into X/Y stores, judges completeness on the rdy rising
// edge, and serves words back through a registered read port.
//
// Ports:
//   clk, rst_n            crypt_clk, async active-low reset
//   ena                   start pulse; re-arms capture from any state
//   rdy                   multiplier ready; its rising edge ends capture
//   rx_wren/addr/din      X word write stream (index 0 = LS word)
//   ry_wren/addr/din      Y word write stream
//   rd_addr, rd_msb       read index (bit 3 picks Y), MSB-first order
//   rd_word               registered read data, 0 unless result_valid
//   busy                  high while armed or capturing
//   result_valid/error    completion status flags
//   word_mask             per-word written flags, Y in bits 15:8
//   checksum              XOR of accepted words when the macro
//                         ECC_RESULT_CHECKSUM_EN is defined, else 0
module ecc_pmul_result_capture #(
   parameter int pWORDS     = 8,
   parameter int pTIMEOUT_W = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic        rdy,
   input  logic        rx_wren,
   input  logic [2:0]  rx_addr,
   input  logic [31:0] rx_din,
   input  logic        ry_wren,
   input  logic [2:0]  ry_addr,
   input  logic [31:0] ry_din,
   input  logic [3:0]  rd_addr,
   input  logic        rd_msb,
   output logic [31:0] rd_word,
   output logic        busy,
   output logic        result_valid,
   output logic        result_error,
   output logic [15:0] word_mask,
   output logic [31:0] checksum
);

   localparam logic [pTIMEOUT_W-1:0] WD_ONE = 1;
   localparam logic [pTIMEOUT_W-1:0] WD_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic                  rdy_q;
   logic [31:0]           x_q [pWORDS];
   logic [31:0]           x_d [pWORDS];
   logic [31:0]           y_q [pWORDS];
   logic [31:0]           y_d [pWORDS];
   logic [15:0]           mask_q, mask_d;
   logic                  valid_q, valid_d;
   logic                  error_q, error_d;
   logic [pTIMEOUT_W-1:0] wd_q, wd_d;
   logic [31:0]           rd_word_q, rd_word_d;
   logic [2:0]            rd_idx;
   logic                  rdy_edge;
   logic                  accept;

   assign busy     = (state_q == S_ARMED) || (state_q == S_CAPTURE);
   assign rdy_edge = rdy & ~rdy_q;
   // Writes coinciding with a re-arm pulse are dropped.
   assign accept   = busy & ~ena;
   assign rd_idx   = rd_msb ? (3'd7 - rd_addr[2:0]) : rd_addr[2:0];

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      valid_d = valid_q;
      error_d = error_q;
      wd_d    = wd_q;
      x_d     = x_q;
      y_d     = y_q;
      if (ena) begin
         state_d = S_ARMED;
         mask_d  = '0;
         valid_d = 1'b0;
         error_d = 1'b0;
         wd_d    = '0;
      end else if (accept) begin
         if (rx_wren) begin
            x_d[rx_addr]           = rx_din;
            mask_d[{1'b0, rx_addr}] = 1'b1;
         end
         if (ry_wren) begin
            y_d[ry_addr]           = ry_din;
            mask_d[{1'b1, ry_addr}] = 1'b1;
         end
         if ((rx_wren | ry_wren) && state_q == S_ARMED) begin
            state_d = S_CAPTURE;
         end
         // Completion judges the mask including this edge's writes;
         // a rdy edge wins over a simultaneous watchdog expiry.
         if (rdy_edge) begin
            state_d = S_DONE;
            valid_d = &mask_d;
            error_d = ~&mask_d;
         end else begin
            wd_d = wd_q + WD_ONE;
            if (wd_d == WD_MAX) begin
               state_d = S_DONE;
               valid_d = 1'b0;
               error_d = 1'b1;
            end
         end
      end
   end

   // Uses the pre-edge store, so a same-edge write returns the old word.
   always_comb begin
      rd_word_d = '0;
      if (valid_q) begin
         rd_word_d = rd_addr[3] ? y_q[rd_idx] : x_q[rd_idx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         rdy_q     <= 1'b1;
         mask_q    <= '0;
         valid_q   <= 1'b0;
         error_q   <= 1'b0;
         wd_q      <= '0;
         rd_word_q <= '0;
         for (int i = 0; i < pWORDS; i++) begin
            x_q[i] <= '0;
            y_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         rdy_q     <= rdy;
         mask_q    <= mask_d;
         valid_q   <= valid_d;
         error_q   <= error_d;
         wd_q      <= wd_d;
         rd_word_q <= rd_word_d;
         x_q       <= x_d;
         y_q       <= y_d;
      end
   end

   assign rd_word      = rd_word_q;
   assign result_valid = valid_q;
   assign result_error = error_q;
   assign word_mask    = mask_q;

`ifdef ECC_RESULT_CHECKSUM_EN
   logic [31:0] cs_q, cs_d;

   always_comb begin
      cs_d = cs_q;
      if (ena) begin
         cs_d = '0;
      end else if (accept) begin
         if (rx_wren) cs_d = cs_d ^ rx_din;
         if (ry_wren) cs_d = cs_d ^ ry_din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cs_q <= '0;
      else        cs_q <= cs_d;
   end

   assign checksum = cs_q;
`else
   assign checksum = 32'h0;
`endif

endmodule
